// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   // Signed variants carry a 0 in the low opcode bit.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring divide step: trial subtract of the divisor from the shifted partial remainder.
module mdu_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   always_comb begin
      q_bit   = (rem_in >= {1'b0, divisor});
      rem_out = q_bit ? WIDTH'(rem_in - {1'b0, divisor}) : WIDTH'(rem_in);
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing registered hi/lo, with flush abort.
// Define FAST_MUL_EN to use a native multiplier (multiply latency 2); divide is unchanged.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned DW = 2 * WIDTH;

   mdu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             signed_q, sa_q, sb_q, is_div_q, dbz_q;
   logic [WIDTH-1:0] m;
   logic [DW-1:0]    acc;

   logic             in_signed_c, a_neg_c, b_neg_c, in_div_c, in_dbz_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [WIDTH:0]   add_sum_c;
   logic [WIDTH-1:0] step_rem_c;
   logic             step_q_c;
   logic [DW-1:0]    mul_mag_c, mul_res_c;
   logic [WIDTH-1:0] quo_c, rem_c;

   // Operand magnitudes and classification at issue
   always_comb begin
      in_signed_c = op_is_signed(op);
      in_div_c    = op_is_div(op);
      in_dbz_c    = in_div_c & (b == '0);
      a_neg_c     = in_signed_c & a[WIDTH-1];
      b_neg_c     = in_signed_c & b[WIDTH-1];
      a_mag_c     = a_neg_c ? (~a + WIDTH'(1)) : a;
      b_mag_c     = b_neg_c ? (~b + WIDTH'(1)) : b;
   end

   // Shift-add step: upper half accumulates, multiplier bits drain from acc[0]
   always_comb begin
      add_sum_c = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? m : '0)};
   end

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  ({acc[DW-1:WIDTH], acc[WIDTH-1]}),
      .divisor (m),
      .rem_out (step_rem_c),
      .q_bit   (step_q_c)
   );

   // Final sign correction
   always_comb begin
`ifdef FAST_MUL_EN
      mul_mag_c = DW'(m) * DW'(acc[WIDTH-1:0]);
`else
      mul_mag_c = acc;
`endif
      mul_res_c = (signed_q & (sa_q ^ sb_q)) ? (~mul_mag_c + DW'(1)) : mul_mag_c;
      quo_c     = (signed_q & (sa_q ^ sb_q)) ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      rem_c     = (signed_q & sa_q) ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         signed_q    <= 1'b0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         is_div_q    <= 1'b0;
         dbz_q       <= 1'b0;
         m           <= '0;
         acc         <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     signed_q <= in_signed_c;
                     sa_q     <= a_neg_c;
                     sb_q     <= b_neg_c;
                     is_div_q <= in_div_c;
                     dbz_q    <= in_dbz_c;
                     m        <= in_div_c ? b_mag_c : a_mag_c;
                     acc      <= {{WIDTH{1'b0}}, (in_dbz_c ? a : (in_div_c ? a_mag_c : b_mag_c))};
                     cnt      <= CNT_W'(WIDTH - 1);
                     busy     <= 1'b1;
`ifdef FAST_MUL_EN
                     state    <= (in_dbz_c || !in_div_c) ? FIX : CALC;
`else
                     state    <= in_dbz_c ? FIX : CALC;
`endif
                  end
               end
               CALC: begin
                  if (is_div_q) acc <= {step_rem_c, acc[WIDTH-2:0], step_q_c};
                  else          acc <= {add_sum_c, acc[WIDTH-1:1]};
                  if (cnt == '0) state <= FIX;
                  else           cnt   <= cnt - CNT_W'(1);
               end
               FIX: begin
                  if (dbz_q) begin
                     hi <= acc[WIDTH-1:0];
                     lo <= '1;
                  end else if (is_div_q) begin
                     hi <= rem_c;
                     lo <= quo_c;
                  end else begin
                     hi <= mul_res_c[DW-1:WIDTH];
                     lo <= mul_res_c[WIDTH-1:0];
                  end
                  done        <= 1'b1;
                  div_by_zero <= dbz_q;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected hi/lo/latency queued at issue, checked at done.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      longint sx, sy, p, q, r;
      logic [63:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.dbz = 1'b0;
      e.lat = 34;
      e.t0  = 0;
      case (o)
         2'b00: begin
            p = sx * sy; u = p;
            e.hi = u[63:32]; e.lo = u[31:0];
`ifdef FAST_MUL_EN
            e.lat = 2;
`endif
         end
         2'b01: begin
            u = {32'b0, x} * {32'b0, y};
            e.hi = u[63:32]; e.lo = u[31:0];
`ifdef FAST_MUL_EN
            e.lat = 2;
`endif
         end
         default: begin
            if (y == 32'd0) begin
               e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 2;
            end else if (o == 2'b10) begin
               q = sx / sy; r = sx % sy;
               u = q; e.lo = u[31:0];
               u = r; e.hi = u[31:0];
            end else begin
               e.lo = x / y; e.hi = x % y;
            end
         end
      endcase
      return e;
   endfunction

   // Called at a negedge; drives a one-cycle start and queues the expectation.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e = model(o, x, y);
      e.t0 = cyc;
      sb.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      exp_t e;
      int   n;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: done never seen, required within 100 cycles", name);
         return;
      end
      checks += 5;
      if (cyc - e.t0 !== e.lat) begin
         errors++; $display("FAIL %s latency: got %0d required %0d", name, cyc - e.t0, e.lat);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL %s busy_in_done: got %b required 0", name, busy);
      end
      if (hi !== e.hi) begin
         errors++; $display("FAIL %s hi: got %h required %h", name, hi, e.hi);
      end
      if (lo !== e.lo) begin
         errors++; $display("FAIL %s lo: got %h required %h", name, lo, e.lo);
      end
      if (div_by_zero !== e.dbz) begin
         errors++; $display("FAIL %s div_by_zero: got %b required %b", name, div_by_zero, e.dbz);
      end
   endtask

   task automatic count_dones(input int cycles, output int cnt_o);
      cnt_o = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) cnt_o++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
         errors++;
         $display("FAIL reset: got busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
                  busy, done, div_by_zero, hi, lo);
      end
   endtask

   task automatic test_mult();
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002); wait_done("mult_neg1x2");
      @(negedge clk);
      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002); wait_done("multu_max_x2");
      @(negedge clk);
      issue(2'b00, 32'd3, 32'hFFFF_FFFB);          wait_done("mult_3x-5");
      @(negedge clk);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000); wait_done("mult_minxmin");
   endtask

   task automatic test_div();
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);          wait_done("div_-7/2");
      @(negedge clk);
      issue(2'b11, 32'd7, 32'd2);                  wait_done("divu_7/2");
      @(negedge clk);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_min/-1");
      @(negedge clk);
      issue(2'b10, 32'd100, 32'hFFFF_FFF9);        wait_done("div_100/-7");
      @(negedge clk);
      issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0010); wait_done("divu_max/16");
   endtask

   task automatic test_div_by_zero();
      issue(2'b11, 32'd7, 32'd0);                  wait_done("divu_7/0");
      @(negedge clk);
      issue(2'b10, 32'hFFFF_FFF9, 32'd0);          wait_done("div_-7/0");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom);
         wait_done("random");
         @(negedge clk);
      end
   endtask

   task automatic test_flush();
      logic [31:0] hi0, lo0;
      int t0, nd;
      hi0 = hi; lo0 = lo;
      op = 2'b00; a = 32'd123; b = 32'd456; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL flush_busy: got %b required 0", busy);
      end
      count_dones(40, nd);
      checks += 2;
      if (nd !== 0) begin
         errors++; $display("FAIL flush_no_done: got %0d pulses required 0", nd);
      end
      if ({hi, lo} !== {hi0, lo0}) begin
         errors++; $display("FAIL flush_hold: got %h_%h required %h_%h", hi, lo, hi0, lo0);
      end
      // flush and start together: nothing starts
      op = 2'b11; a = 32'd9; b = 32'd4; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL flush_start_busy: got %b required 0", busy);
      end
      count_dones(40, nd);
      checks++;
      if (nd !== 0) begin
         errors++; $display("FAIL flush_start_no_done: got %0d pulses required 0", nd);
      end
      // flush while in FIX (divide-by-zero path reaches FIX after one edge)
      op = 2'b11; a = 32'd55; b = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      count_dones(10, nd);
      checks += 2;
      if (nd !== 0 || done !== 1'b0) begin
         errors++; $display("FAIL flush_fix_no_done: got %0d pulses required 0", nd);
      end
      if ({hi, lo} !== {hi0, lo0}) begin
         errors++; $display("FAIL flush_fix_hold: got %h_%h required %h_%h", hi, lo, hi0, lo0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] hi1;
      int nd;
      issue(2'b01, 32'd1000, 32'd1000);
      wait_done("b2b_first");
      hi1 = hi;
      issue(2'b10, 32'hFFFF_FF00, 32'd7);
      checks++;
      if (hi !== hi1) begin
         errors++; $display("FAIL hold_after_start: got %h required %h", hi, hi1);
      end
      wait_done("b2b_second");
      @(negedge clk);
      // start mid-operation is ignored
      issue(2'b11, 32'd50, 32'd5);
      repeat (5) @(negedge clk);
      op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");
      count_dones(40, nd);
      checks++;
      if (nd !== 0) begin
         errors++; $display("FAIL single_done: got %0d extra pulses required 0", nd);
      end
   endtask

   task automatic test_reset_mid_op();
      op = 2'b10; a = 32'd77; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1; flush = 1'b1;
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      test_reset();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_mult();
      @(negedge clk);
      test_div();
      @(negedge clk);
      test_div_by_zero();
      @(negedge clk);
      test_random();
      test_flush();
      @(negedge clk);
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
